// File: rtl/weight_buffer_sequencer.sv
// Weight tile loader for a systolic array: pops rows from the weight FIFO into
// a ring of NUM_BUF tile buffers and hands full tiles to compute in order.
module weight_buffer_sequencer #(
  parameter int MUL_SIZE = 32,
  parameter int NUM_BUF  = 2,
  parameter int TILE_W   = 10,
  localparam int SEL_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_valid_i,
  input  logic [TILE_W-1:0] instr_tiles_i,
  input  logic              iq_empty_i,
  input  logic              weight_fifo_valid_i,
  input  logic              next_weight_tile_i,
  output logic              read_instruction_o,
  output logic              weight_fifo_rd_o,
  output logic [MUL_SIZE-1:0] load_weights_o,
  output logic [SEL_W-1:0]  load_buf_sel_o,
  output logic [SEL_W-1:0]  compute_buf_sel_o,
  output logic              compute_weights_rdy_o,
  output logic              buffers_full_o,
  output logic              done_o,
  output logic              underflow_err_o,
  output logic [1:0]        state_o
);

  localparam int ROW_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
  localparam int CNT_W = $clog2(NUM_BUF + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  row_cnt;
  logic [CNT_W-1:0]  buf_count, buf_nxt;
  logic [TILE_W-1:0] tiles_total, tiles_loaded, tiles_consumed;
  logic [TILE_W-1:0] loaded_nxt, consumed_nxt;
  logic [SEL_W-1:0]  load_sel, comp_sel;
  logic              req_pending, read_q, done_q, underflow_q;
  logic              pop, tile_done, consume, finish, zero_instr, accept;

  // Handshakes: read_instruction_o is a one-shot request answered by
  // instr_valid_i (any later cycle); a FIFO row moves when valid & rd are both high.
  assign pop          = (state == S_LOAD) && weight_fifo_valid_i;
  assign tile_done    = pop && (row_cnt == ROW_W'(MUL_SIZE - 1));
  assign consume      = next_weight_tile_i && ((buf_count != '0) || tile_done);
  assign loaded_nxt   = tiles_loaded + TILE_W'(tile_done);
  assign consumed_nxt = tiles_consumed + TILE_W'(consume);
  assign finish       = (state == S_DRAIN) && (consumed_nxt == tiles_total);
  assign accept       = (state == S_IDLE) && instr_valid_i;
  assign zero_instr   = accept && (instr_tiles_i == '0);

  function automatic logic [SEL_W-1:0] adv_sel(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NUM_BUF - 1)) ? '0 : s + SEL_W'(1);
  endfunction

  always_comb begin
    buf_nxt = buf_count;
    if (tile_done && !consume) begin
      buf_nxt = buf_count + CNT_W'(1);
    end else if (consume && !tile_done) begin
      buf_nxt = buf_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && (instr_tiles_i != '0)) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // The last tile wins over a full ring: nothing more to load either way.
        if (tile_done && (loaded_nxt == tiles_total)) begin
          state_nxt = S_DRAIN;
        end else if (buf_nxt == CNT_W'(NUM_BUF)) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (consume) state_nxt = S_LOAD;
      end
      S_DRAIN: begin
        if (finish) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_cnt        <= '0;
      buf_count      <= '0;
      tiles_total    <= '0;
      tiles_loaded   <= '0;
      tiles_consumed <= '0;
      load_sel       <= '0;
      comp_sel       <= '0;
      req_pending    <= 1'b0;
      read_q         <= 1'b0;
      done_q         <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      read_q <= 1'b0;
      if (instr_valid_i) begin
        req_pending <= 1'b0;
      end else if ((state == S_IDLE) && !iq_empty_i && !req_pending) begin
        req_pending <= 1'b1;
        read_q      <= 1'b1;
      end

      if (accept && (instr_tiles_i != '0)) tiles_total <= instr_tiles_i;
      done_q <= finish || zero_instr;
      if (next_weight_tile_i && !consume) underflow_q <= 1'b1;

      if ((state == S_IDLE) || finish) begin
        row_cnt        <= '0;
        buf_count      <= '0;
        tiles_loaded   <= '0;
        tiles_consumed <= '0;
        load_sel       <= '0;
        comp_sel       <= '0;
      end else begin
        if (pop) row_cnt <= tile_done ? '0 : row_cnt + ROW_W'(1);
        buf_count      <= buf_nxt;
        tiles_loaded   <= loaded_nxt;
        tiles_consumed <= consumed_nxt;
        if (tile_done) load_sel <= adv_sel(load_sel);
        if (consume)   comp_sel <= adv_sel(comp_sel);
      end
    end
  end

  always_comb begin
    load_weights_o = '0;
    if (pop) load_weights_o[row_cnt] = 1'b1;
  end

  assign weight_fifo_rd_o      = pop;
  assign read_instruction_o    = read_q;
  assign done_o                = done_q;
  assign underflow_err_o       = underflow_q;
  assign load_buf_sel_o        = load_sel;
  assign compute_buf_sel_o     = comp_sel;
  assign compute_weights_rdy_o = (buf_count != '0);
  assign buffers_full_o        = (buf_count == CNT_W'(NUM_BUF));
  assign state_o               = state;

endmodule

// File: tb/tb_weight_buffer_sequencer.sv
// Bench for weight_buffer_sequencer: two instances (2 and 3 buffers) share the
// stimulus and are each checked every cycle against a count-based model.
module tb_weight_buffer_sequencer;
  localparam int MS = 4;
  localparam int TW = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iv, ie, fv, nt;
  logic [TW-1:0] it;

  logic       read_a, rd_a, rdy_a, full_a, done_a, uf_a;
  logic [3:0] lw_a;
  logic [0:0] lsel_a, csel_a;
  logic [1:0] st_a;
  logic       read_b, rd_b, rdy_b, full_b, done_b, uf_b;
  logic [3:0] lw_b;
  logic [1:0] lsel_b, csel_b, st_b;

  weight_buffer_sequencer #(.MUL_SIZE(MS), .NUM_BUF(2), .TILE_W(TW)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(iv), .instr_tiles_i(it),
    .iq_empty_i(ie), .weight_fifo_valid_i(fv), .next_weight_tile_i(nt),
    .read_instruction_o(read_a), .weight_fifo_rd_o(rd_a), .load_weights_o(lw_a),
    .load_buf_sel_o(lsel_a), .compute_buf_sel_o(csel_a),
    .compute_weights_rdy_o(rdy_a), .buffers_full_o(full_a), .done_o(done_a),
    .underflow_err_o(uf_a), .state_o(st_a));

  weight_buffer_sequencer #(.MUL_SIZE(MS), .NUM_BUF(3), .TILE_W(TW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(iv), .instr_tiles_i(it),
    .iq_empty_i(ie), .weight_fifo_valid_i(fv), .next_weight_tile_i(nt),
    .read_instruction_o(read_b), .weight_fifo_rd_o(rd_b), .load_weights_o(lw_b),
    .load_buf_sel_o(lsel_b), .compute_buf_sel_o(csel_b),
    .compute_weights_rdy_o(rdy_b), .buffers_full_o(full_b), .done_o(done_b),
    .underflow_err_o(uf_b), .state_o(st_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observation layout: [13]read [12]rd [11:8]lw [7:6]lsel [5:4]csel [3]rdy [2]full [1]done [0]uf
  logic [13:0] obs[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [13:0] pack(input logic r, input logic p, input logic [3:0] w,
                                       input logic [1:0] ls, input logic [1:0] cs,
                                       input logic rd, input logic fl, input logic dn,
                                       input logic u);
    return {r, p, w, ls, cs, rd, fl, dn, u};
  endfunction

  // Reference model: progress kept as plain tile/row counts; buffered tiles
  // and selectors are derived from the counts.
  localparam int M_IDLE = 0, M_LOAD = 1, M_FULL = 2, M_DRAIN = 3;
  int nb[2] = '{2, 3};
  int m_mode[2], m_total[2], m_loaded[2], m_consumed[2], m_pops[2];
  bit m_pend[2], m_read[2], m_done[2], m_uf[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = M_IDLE; m_total[d] = 0; m_loaded[d] = 0; m_consumed[d] = 0;
      m_pops[d] = 0; m_pend[d] = 0; m_read[d] = 0; m_done[d] = 0; m_uf[d] = 0;
    end
  endtask

  function automatic logic [13:0] model_expect(input int d);
    int buffered = m_loaded[d] - m_consumed[d];
    logic pop = (m_mode[d] == M_LOAD) && fv;
    logic [3:0] lw = pop ? 4'(1 << (m_pops[d] % MS)) : 4'h0;
    return pack(m_read[d], pop, lw, 2'(m_loaded[d] % nb[d]), 2'(m_consumed[d] % nb[d]),
                buffered != 0, buffered == nb[d], m_done[d], m_uf[d]);
  endfunction

  task automatic model_advance(input int d);
    int  mode0 = m_mode[d];
    int  buffered = m_loaded[d] - m_consumed[d];
    bit  pop = (mode0 == M_LOAD) && fv;
    bit  complete = pop && ((m_pops[d] % MS) == MS - 1);
    bit  cons = nt && (buffered > 0 || complete);
    if (nt && !cons) m_uf[d] = 1;
    m_read[d] = 0;
    m_done[d] = 0;
    if (mode0 == M_IDLE) begin
      if (iv) begin
        m_pend[d] = 0;
        if (it != 0) begin m_total[d] = int'(it); m_mode[d] = M_LOAD; end
        else m_done[d] = 1;
      end else if (!ie && !m_pend[d]) begin
        m_read[d] = 1; m_pend[d] = 1;
      end
    end else if (iv) begin
      m_pend[d] = 0;
    end
    if (pop) m_pops[d]++;
    if (complete) m_loaded[d]++;
    if (cons) m_consumed[d]++;
    case (mode0)
      M_LOAD: begin
        if (complete && m_loaded[d] == m_total[d]) m_mode[d] = M_DRAIN;
        else if (m_loaded[d] - m_consumed[d] == nb[d]) m_mode[d] = M_FULL;
      end
      M_FULL: if (cons) m_mode[d] = M_LOAD;
      M_DRAIN: begin
        if (m_consumed[d] == m_total[d]) begin
          m_mode[d] = M_IDLE; m_done[d] = 1;
          m_loaded[d] = 0; m_consumed[d] = 0; m_pops[d] = 0;
        end
      end
      default: ;
    endcase
  endtask

  // One cycle: called at a falling edge with inputs already driven.
  task automatic step();
    logic [13:0] exp;
    #1;
    obs[0] = pack(read_a, rd_a, lw_a, {1'b0, lsel_a}, {1'b0, csel_a}, rdy_a, full_a, done_a, uf_a);
    obs[1] = pack(read_b, rd_b, lw_b, lsel_b, csel_b, rdy_b, full_b, done_b, uf_b);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        model_reset();
        exp = '0;
      end else begin
        exp = model_expect(d);
      end
      check(d == 0 ? "model_dut_a" : "model_dut_b", 32'(obs[d]), 32'(exp));
      if (rst_n) model_advance(d);
    end
    cyc++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0; iv = 1'b0; it = '0; ie = 1'b1; fv = 1'b0; nt = 1'b0;
    step();
    check("reset_a", 32'(obs[0]), 32'h0);
    check("reset_b", 32'(obs[1]), 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [TW-1:0] tiles);
    logic seen = 1'b0;
    ie = 1'b0; iv = 1'b0; nt = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      seen = obs[0][13];
    end
    check("issue_request", 32'(seen), 32'h1);
    iv = 1'b1; it = tiles; ie = 1'b1;
    step();
    iv = 1'b0; it = '0;
  endtask

  typedef struct {
    logic ie, iv;
    logic [TW-1:0] it;
    logic fv, nt;
    logic read, rd;
    logic [3:0] lw;
    logic rdy, full, done;
  } vec_t;
  vec_t tbl[13];

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pops, dones, done_at, viol;
    logic [1:0] last_sel;

    // Three tiles, FIFO always valid, no consume: two tiles fill the ring.
    tbl[0]  = '{1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 10'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};

    iv = 1'b0; it = '0; ie = 1'b1; fv = 1'b0; nt = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      ie = tbl[i].ie; iv = tbl[i].iv; it = tbl[i].it; fv = tbl[i].fv; nt = tbl[i].nt;
      step();
      check($sformatf("table_row%0d", i),
            32'({obs[0][13], obs[0][12], obs[0][11:8], obs[0][3], obs[0][2], obs[0][1]}),
            32'({tbl[i].read, tbl[i].rd, tbl[i].lw, tbl[i].rdy, tbl[i].full, tbl[i].done}));
    end

    // Three consumes spaced six cycles: third tile loads, then drain and done.
    pops = 0; dones = 0; done_at = -1;
    iv = 1'b0; it = '0; ie = 1'b1; fv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nt = (i == 0 || i == 6 || i == 12);
      step();
      if (obs[0][12]) pops++;
      if (obs[0][1]) begin dones++; done_at = i; end
    end
    nt = 1'b0;
    check("drain_pops_a", 32'(pops), 32'd4);
    check("done_count_a", 32'(dones), 32'd1);
    check("done_cycle_a", 32'(done_at), 32'd13);
    ie = 1'b0;
    step();
    step();
    check("idle_rerequest_a", 32'(obs[0][13]), 32'h1);
    do_reset();

    // Tile completion coincident with a consume while one tile is buffered.
    issue(10'd3);
    fv = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("coin_pre_a", 32'(obs[0][7:2]), 32'b0100_10);
    nt = 1'b1;
    step();
    nt = 1'b0;
    step();
    check("coin_post_a", 32'(obs[0][7:2]), 32'b0001_10);
    check("coin_post_b", 32'(obs[1][7:2]), 32'b1001_10);
    do_reset();

    // Consume request with nothing buffered sets a sticky error.
    ie = 1'b1; nt = 1'b1;
    step();
    nt = 1'b0;
    step();
    check("underflow_set_a", 32'({obs[0][0], obs[0][3]}), 32'b10);
    for (int i = 0; i < 5; i++) step();
    check("underflow_sticky_a", 32'(obs[0][0]), 32'h1);
    check("underflow_sticky_b", 32'(obs[1][0]), 32'h1);
    do_reset();

    // Three buffers with a FIFO that is valid every other cycle.
    issue(10'd4);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
    got_q.delete();
    pops = 0; viol = 0; last_sel = 2'd3;
    for (int k = 0; k < 30; k++) begin
      fv = ((k % 2) == 0);
      step();
      if (obs[1][12]) pops++;
      if (obs[1][12] && !fv) viol++;
      if (obs[1][7:6] != last_sel) begin
        got_q.push_back(obs[1][7:6]);
        last_sel = obs[1][7:6];
      end
    end
    check("toggle_pops_b", 32'(pops), 32'd12);
    check("toggle_invalid_pops_b", 32'(viol), 32'd0);
    check("toggle_sel_len_b", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("toggle_sel_seq_b", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    do_reset();

    // Asynchronous reset in the middle of the second tile (row 2).
    issue(10'd3);
    fv = 1'b1;
    for (int i = 0; i < 6; i++) step();
    #1;
    check("pre_reset_row2_a", 32'(lw_a), 32'h4);
    rst_n = 1'b0;
    #1;
    check("async_reset_a", 32'(pack(read_a, rd_a, lw_a, {1'b0, lsel_a}, {1'b0, csel_a},
                                    rdy_a, full_a, done_a, uf_a)), 32'h0);
    check("async_reset_b", 32'(pack(read_b, rd_b, lw_b, lsel_b, csel_b,
                                    rdy_b, full_b, done_b, uf_b)), 32'h0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1; ie = 1'b0; fv = 1'b1;
    step();
    step();
    check("post_reset_request_a", 32'(obs[0][13]), 32'h1);

    // Random traffic against the model, with periodic resets.
    for (int k = 0; k < 600; k++) begin
      if (k % 150 == 0) do_reset();
      ie = ($urandom_range(0, 3) == 0);
      iv = ($urandom_range(0, 5) == 0);
      it = TW'($urandom_range(0, 4));
      fv = ($urandom_range(0, 9) < 7);
      nt = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
